// File: rtl/core0_alu_pkg.sv
// Shared ALU definitions for core0: opcode constants used by alu_control and
// by the multi-cycle mul/div sequencer, plus the sequencer's op/state enums.
package core0_alu_pkg;

    // 3-bit ALU opcodes; the sequencer only ever drives ALU_OP_ADD.
    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;
    localparam logic [2:0] ALU_OP_SLL = 3'd5;
    localparam logic [2:0] ALU_OP_SRL = 3'd6;
    localparam logic [2:0] ALU_OP_SLT = 3'd7;

    typedef enum logic {
        MULDIV_MUL = 1'b0,
        MULDIV_DIV = 1'b1
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL (WxW->2W) and DIVU/REMU sequencer. It owns no
// arithmetic array: each RUN cycle it drives the core's shared ALU adder and
// folds the returned sum/carry into a shift-and-add (MUL) or restoring (DIV)
// step. One bit is retired per cycle, so an operation takes W RUN cycles.
module alu_muldiv_seq
    import core0_alu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [WORD_WIDTH-1:0] operand_a,
    input  logic [WORD_WIDTH-1:0] operand_b,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] alu_out,
    input  logic                  alu_oc,
    output logic                  alu_sel,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    output logic                  alu_ic,
    output logic [2:0]            alu_opcode,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result_lo,
    output logic [WORD_WIDTH-1:0] result_hi
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_WIDTH - 1);

    muldiv_state_e state_reg, state_next;
    muldiv_op_e    op_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic [W-1:0]  lo_reg, lo_next;
    logic [W-1:0]  mc_reg;
    logic [W-1:0]  result_lo_reg, result_hi_reg;
    logic [W-1:0]  div_shift;
    logic          div_keep;

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    // Its true top bit (acc_reg[W-1]) falls off here and is folded into div_keep.
    assign div_shift = {acc_reg[W-2:0], lo_reg[W-1]};

    // Next-state and bit counter: W RUN cycles, then a single DONE cycle.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    count_next = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == LAST_COUNT) begin
                    state_next = DONE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // One algorithm step: drive the ALU operands and form the next acc/lo
    // from the sum the ALU returns in the same cycle.
    always_comb begin
        alu_sel    = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ic     = 1'b0;
        alu_opcode = ALU_OP_ADD;
        div_keep   = 1'b0;
        acc_next   = acc_reg;
        lo_next    = lo_reg;
        if (state_reg == RUN) begin
            alu_sel = 1'b1;
            if (op_reg == MULDIV_MUL) begin
                // Add the multiplicand when the current multiplier bit is set,
                // then shift the 2W-bit {acc, lo} pair right by one.
                alu_a    = acc_reg;
                alu_b    = lo_reg[0] ? mc_reg : '0;
                acc_next = {alu_oc, alu_out[W-1:1]};
                lo_next  = {alu_out[0], lo_reg[W-1:1]};
            end else begin
                // Trial subtract via A + ~B + 1; carry out means no borrow.
                alu_a    = div_shift;
                alu_b    = ~mc_reg;
                alu_ic   = 1'b1;
                div_keep = alu_oc | acc_reg[W-1];
                acc_next = div_keep ? alu_out : div_shift;
                lo_next  = {lo_reg[W-2:0], div_keep};
            end
        end
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            op_reg        <= MULDIV_MUL;
            acc_reg       <= '0;
            lo_reg        <= '0;
            mc_reg        <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (state_reg == IDLE && start) begin
                acc_reg <= '0;
                if (op) begin
                    op_reg <= MULDIV_DIV;
                    lo_reg <= operand_a;
                    mc_reg <= operand_b;
                end else begin
                    op_reg <= MULDIV_MUL;
                    lo_reg <= operand_b;
                    mc_reg <= operand_a;
                end
            end else if (state_reg == RUN && !abort) begin
                acc_reg <= acc_next;
                lo_reg  <= lo_next;
                // Capture the post-final-step values so result_* are valid
                // in the DONE cycle itself.
                if (count_reg == LAST_COUNT) begin
                    result_hi_reg <= acc_next;
                    result_lo_reg <= lo_next;
                end
            end
        end
    end

    // A flush arriving in the DONE cycle suppresses the completion pulse.
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE) && !abort;
    assign result_lo = result_lo_reg;
    assign result_hi = result_hi_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: provides the combinational ALU adder, checks the
// DUT every cycle against an arithmetic reference model (plain * / %), and
// pins the model with hand-computed directed cases.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         abort;
    logic [W-1:0] alu_out;
    logic         alu_oc;
    logic         alu_sel;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_ic;
    logic [2:0]   alu_opcode;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;

    logic [W:0]   alu_sum;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    alu_muldiv_seq #(.WORD_WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .abort      (abort),
        .alu_out    (alu_out),
        .alu_oc     (alu_oc),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ic     (alu_ic),
        .alu_opcode (alu_opcode),
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi)
    );

    // The core's shared ALU adder.
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_ic};
    assign alu_out = alu_sum[W-1:0];
    assign alu_oc  = alu_sum[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} straight from arithmetic.
    function automatic logic [2*W-1:0] ref_result(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (!o) begin
            p = (2*W)'(a) * (2*W)'(b);
            return p;
        end
        if (b == '0)
            return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    // Behavioural model: 0 = idle, 1 = running (m_left cycles to go), 2 = done.
    int           m_state = 0;
    int           m_left  = 0;
    logic [W-1:0] m_pend_lo = '0, m_pend_hi = '0;
    logic [W-1:0] m_res_lo  = '0, m_res_hi  = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_state  <= 0;
            m_left   <= 0;
            m_res_lo <= '0;
            m_res_hi <= '0;
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state <= 1;
                    m_left  <= W;
                    {m_pend_hi, m_pend_lo} <= ref_result(op, operand_a, operand_b);
                end
                1: if (abort) begin
                    m_state <= 0;
                end else if (m_left == 1) begin
                    m_state  <= 2;
                    m_res_lo <= m_pend_lo;
                    m_res_hi <= m_pend_hi;
                end else begin
                    m_left <= m_left - 1;
                end
                default: m_state <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", W'(busy), W'(m_state != 0));
            chk("alu_sel", W'(alu_sel), W'(m_state == 1));
            chk("done", W'(done), W'((m_state == 2) && !abort));
            chk("result_lo", result_lo, m_res_lo);
            chk("result_hi", result_hi, m_res_hi);
            chk("alu_opcode", W'(alu_opcode), W'(3'd0));
            if (m_state != 1) begin
                chk("alu_a_idle", alu_a, '0);
                chk("alu_b_idle", alu_b, '0);
                chk("alu_ic_idle", W'(alu_ic), '0);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the done cycle.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input string name, input int inject);
        int n;
        int sel_n;
        logic seen;
        op = o; operand_a = x; operand_b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        n = 1; sel_n = 0; seen = 1'b0;
        while (n <= W + 8 && !seen) begin
            if (n == inject) begin
                start = 1'b1; op = ~o; operand_a = 32'h1234_5678; operand_b = 32'h3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (alu_sel) sel_n++;
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        chk($sformatf("%s_done_seen", name), W'(seen), W'(1));
        if (seen) begin
            chk($sformatf("%s_latency", name), W'(n), W'(W + 1));
            chk($sformatf("%s_sel_cycles", name), W'(sel_n), W'(W));
            chk($sformatf("%s_lo", name), result_lo, exp_lo);
            chk($sformatf("%s_hi", name), result_hi, exp_hi);
        end
        $display("op %s a=%h b=%h -> lo=%h hi=%h cycles=%0d", name, x, y, result_lo, result_hi, n);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Random op with optional abort and spurious start; results checked by the model.
    task automatic run_rand(input int idx);
        int n;
        int abort_at;
        int inject;
        logic fin;
        logic o;
        logic [W-1:0] x, y;
        o = 1'($urandom_range(0, 1));
        x = pick_operand();
        y = pick_operand();
        abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W + 1) : 0;
        inject   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0;
        op = o; operand_a = x; operand_b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; fin = 1'b0;
        while (n <= W + 8 && !fin) begin
            start = (n == inject);
            abort = (n == abort_at);
            if (n == inject) begin
                operand_a = $urandom; operand_b = $urandom;
            end
            @(negedge clk);
            if (done || n == abort_at) fin = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        chk($sformatf("rand%0d_finished", idx), W'(fin), W'(1));
        $display("rand %0d op=%0d a=%h b=%h abort_at=%0d -> lo=%h hi=%h", idx, o, x, y, abort_at, result_lo, result_hi);
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 1'b0; abort = 1'b0;
        operand_a = '0; operand_b = '0;
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_alu_sel", W'(alu_sel), '0);
        chk("rst_result_lo", result_lo, '0);
        chk("rst_result_hi", result_hi, '0);
        reset_n = 1'b1;

        run_op(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, "mul_7x6", 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "mul_max", 0);
        run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "div_100_7", 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_msb", 0);
        run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "div_5_0", 0);
        run_op(1'b0, 32'd3, 32'd4, 32'd12, 32'd0, "mul_3x4", 0);

        // DIV aborted in RUN cycle 10: back to IDLE, previous result kept.
        op = 1'b1; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_keep_lo", result_lo, 32'd12);
        chk("abort_keep_hi", result_hi, 32'd0);
        $display("abort in cycle 10 -> busy=%0d result_lo=%h", busy, result_lo);
        run_op(1'b0, 32'd11, 32'd13, 32'd143, 32'd0, "mul_after_abort", 0);

        // Start pulsed mid-operation must be ignored.
        run_op(1'b0, 32'd9, 32'd9, 32'd81, 32'd0, "mul_9x9_start_ignored", 5);

        // Reset mid-RUN clears everything.
        op = 1'b0; operand_a = 32'd5; operand_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        chk("midrst_alu_sel", W'(alu_sel), '0);
        chk("midrst_alu_a", alu_a, '0);
        chk("midrst_alu_b", alu_b, '0);
        chk("midrst_result_lo", result_lo, '0);
        chk("midrst_result_hi", result_hi, '0);
        $display("reset mid-run -> busy=%0d result_lo=%h result_hi=%h", busy, result_lo, result_hi);

        for (int i = 0; i < 60; i++) begin
            run_rand(i);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
